// File: rtl/enc_monitor_pkg.sv
// Shared types and constants for the ADC encode-clock monitor.
// Holds the FSM state encoding, counter widths and the period tolerance helper.
package enc_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        TRACK,
        RUN
    } state_t;

    localparam int PERIOD_W = 6;
    localparam int CNT_W    = 8;

    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
    localparam logic [CNT_W-1:0]    CNT_MAX    = '1;

    // Distance is taken on the larger side first so the unsigned subtraction never wraps.
    function automatic logic out_of_tol(input int unsigned measured,
                                        input int unsigned nominal,
                                        input int unsigned tol);
        if (measured > nominal) begin
            return (measured - nominal) > tol;
        end
        return (nominal - measured) > tol;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for a single asynchronous bit, plus rising-edge detect
// on the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    // NOTE: non-blocking assignments make these three flops a true shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= d;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~sync_d;

endmodule

// File: rtl/enc_monitor.sv
// Monitors the ADC encode clock against ADC_CLK once the DCM has locked and settled.
// Period/error/lock-loss statistics are built only when ENC_MON_STATS_EN is defined.
module enc_monitor
    import enc_monitor_pkg::*;
#(
    parameter int EXP_PERIOD = 16,
    parameter int TOL        = 1,
    parameter int SETTLE_CYC = 1024
) (
    input  logic                ADC_CLK,
    input  logic                RST,
    input  logic                ADC_ENC,
    input  logic                LOCKED,
    input  logic                CLR_CNT,
    output logic                ENC_STROBE,
    output logic                READY,
    output logic [PERIOD_W-1:0] PERIOD,
    output logic [CNT_W-1:0]    PERIOD_ERR_CNT,
    output logic [CNT_W-1:0]    LOCK_LOSS_CNT
);

    localparam int                  SETTLE_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [PERIOD_W-1:0] TIMEOUT_CNT = PERIOD_W'(2 * EXP_PERIOD);

    logic enc_edge;
    logic lock_s;
    logic unused_enc_level;
    logic unused_lock_rise;

    sync_edge u_enc_sync (
        .clk   (ADC_CLK),
        .rst   (RST),
        .d     (ADC_ENC),
        .level (unused_enc_level),
        .rise  (enc_edge)
    );

    sync_edge u_lock_sync (
        .clk   (ADC_CLK),
        .rst   (RST),
        .d     (LOCKED),
        .level (lock_s),
        .rise  (unused_lock_rise)
    );

    state_t              state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                track_edge;
    logic [PERIOD_W-1:0] period_cnt;

    logic run_active;
    logic period_bad;
    logic timeout_hit;
    logic err_hit;
    logic loss_hit;

    assign run_active  = (state == RUN) && lock_s;
    assign period_bad  = run_active && enc_edge &&
                         out_of_tol(32'(period_cnt), EXP_PERIOD, TOL);
    assign timeout_hit = run_active && !enc_edge && (period_cnt == TIMEOUT_CNT);
    assign err_hit     = period_bad || timeout_hit;
    assign loss_hit    = !lock_s && ((state == TRACK) || (state == RUN));

    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            state      <= IDLE;
            settle_cnt <= '0;
            track_edge <= 1'b0;
            READY      <= 1'b0;
            ENC_STROBE <= 1'b0;
        end else begin
            ENC_STROBE <= 1'b0;
            if (!lock_s) begin
                state      <= IDLE;
                settle_cnt <= '0;
                READY      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end
                    SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state      <= TRACK;
                            track_edge <= 1'b0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    // Two edges are needed so the first RUN period is a full measurement.
                    TRACK: begin
                        if (enc_edge) begin
                            if (track_edge) begin
                                state <= RUN;
                                READY <= 1'b1;
                            end else begin
                                track_edge <= 1'b1;
                            end
                        end
                    end
                    RUN:     ENC_STROBE <= enc_edge;
                    default: state      <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            period_cnt <= '0;
        end else if (!lock_s || !((state == TRACK) || (state == RUN))) begin
            period_cnt <= '0;
        end else if (enc_edge || timeout_hit) begin
            period_cnt <= PERIOD_W'(1);
        end else if (period_cnt != PERIOD_MAX) begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

`ifdef ENC_MON_STATS_EN
    // A clear wins over an increment landing in the same cycle.
    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            PERIOD         <= '0;
            PERIOD_ERR_CNT <= '0;
            LOCK_LOSS_CNT  <= '0;
        end else begin
            if (run_active && enc_edge) begin
                PERIOD <= period_cnt;
            end
            if (CLR_CNT) begin
                PERIOD_ERR_CNT <= '0;
                LOCK_LOSS_CNT  <= '0;
            end else begin
                if (err_hit && (PERIOD_ERR_CNT != CNT_MAX)) begin
                    PERIOD_ERR_CNT <= PERIOD_ERR_CNT + 1'b1;
                end
                if (loss_hit && (LOCK_LOSS_CNT != CNT_MAX)) begin
                    LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 1'b1;
                end
            end
        end
    end
`else
    assign PERIOD         = '0;
    assign PERIOD_ERR_CNT = '0;
    assign LOCK_LOSS_CNT  = '0;

    logic unused_stats;
    assign unused_stats = ^{CLR_CNT, err_hit, loss_hit};
`endif

endmodule

// File: doc/enc_monitor.md
ENC_MONITOR -- requirements
Module: enc_monitor

Interface
REQ-001 SHALL have parameter EXP_PERIOD, 16, nominal ADC_ENC period in ADC_CLK cycles.
REQ-002 SHALL have parameter TOL, 1, allowed period deviation in cycles, inclusive.
REQ-003 SHALL have parameter SETTLE_CYC, 1024, cycles LOCKED must stay high before tracking starts.
REQ-004 SHALL have port ADC_CLK, input, 1, the only clock (160 MHz).
REQ-005 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-006 SHALL have port ADC_ENC, input, 1, 10 MHz encode clock, sampled as data.
REQ-007 SHALL have port LOCKED, input, 1, DCM lock status, asynchronous to ADC_CLK.
REQ-008 SHALL have port CLR_CNT, input, 1, single-cycle clear of the statistics counters.
REQ-009 SHALL have port ENC_STROBE, output, 1, one-cycle pulse per ADC_ENC rising edge while in RUN.
REQ-010 SHALL have port READY, output, 1, high only in RUN.
REQ-011 SHALL have port PERIOD, output, 6, last measured edge-to-edge period.
REQ-012 SHALL have port PERIOD_ERR_CNT, output, 8, saturating count of period errors.
REQ-013 SHALL have port LOCK_LOSS_CNT, output, 8, saturating count of lock losses from TRACK or RUN.

Function
REQ-014 SHALL pass ADC_ENC and LOCKED each through a 2-FF synchronizer; ENC edge = sync high and previous sync low. Latency from input change to internal use is 2 cycles, plus 1 cycle for edge detect.
REQ-015 SHALL implement the FSM IDLE->SETTLE (on synced LOCKED=1) ->TRACK (after SETTLE_CYC consecutive LOCKED cycles) ->RUN (on the second ENC edge seen in TRACK).
REQ-016 SHALL return to IDLE from any state in the cycle after synced LOCKED=0; a lock loss in SETTLE restarts settling without counting.
REQ-017 SHALL, on an IDLE entry from TRACK or RUN, increment LOCK_LOSS_CNT, saturating at 255.
REQ-018 SHALL keep a 6-bit period counter that resets to 1 on each ENC edge and saturates at 63; on each edge in RUN, PERIOD <= counter value.
REQ-019 SHALL flag a period error in RUN when |measured - EXP_PERIOD| > TOL, using unsigned compare without wrap.
REQ-020 SHALL flag a timeout error in RUN when the counter reaches 2*EXP_PERIOD without an edge; one error per timeout; the counter then restarts at 1.
REQ-021 SHALL increment PERIOD_ERR_CNT once per error, saturating at 255; an error does not leave RUN.
REQ-022 SHALL assert ENC_STROBE registered, exactly one cycle per edge, only in RUN, never in the cycle of the transition into RUN.
REQ-023 SHALL give CLR_CNT priority over a simultaneous increment: both counters become 0 and that increment is lost.

Reset
REQ-024 SHALL on RST: FSM=IDLE, synchronizers=0, ENC_STROBE=0, READY=0, PERIOD=0, both counters=0, settle and period counters=0.
REQ-025 SHALL when RST is asserted mid-RUN drop READY and ENC_STROBE in the next cycle and not count a lock loss.

Configuration
REQ-026 SHALL honour macro ENC_MON_STATS_EN: when defined, PERIOD, PERIOD_ERR_CNT and LOCK_LOSS_CNT are as specified; when undefined, these outputs are tied to 0, the counters are not built, and the FSM and strobe behaviour is unchanged.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, SETTLE, TRACK, RUN), counter widths (6, 8) and saturation constants in package enc_monitor_pkg.
REQ-028 SHALL use one sub-module, sync_edge: 2-FF synchronizer plus rising-edge detect, instantiated for ADC_ENC (edge used) and LOCKED (level used).

Verification
REQ-029 Bench SHALL cover: LOCKED=1, ENC period 16 -> READY after 1024+settling cycles and second edge; ENC_STROBE every 16 cycles; PERIOD=16; PERIOD_ERR_CNT=0.
REQ-030 Bench SHALL cover: in RUN, one ENC period of 18 -> PERIOD_ERR_CNT=1, PERIOD=18; a period of 17 -> no error.
REQ-031 Bench SHALL cover: ENC stuck low in RUN for 70 cycles -> exactly 2 errors from timeouts at counts 32 and 32, READY stays 1.
REQ-032 Bench SHALL cover: LOCKED dropped for 3 cycles in RUN -> READY=0 and LOCK_LOSS_CNT=1; the full 1024-cycle settle is repeated before READY returns.
REQ-033 Bench SHALL cover: 300 forced errors -> PERIOD_ERR_CNT=255; CLR_CNT in the same cycle as an error -> counter reads 0.
REQ-034 Bench SHALL cover: RST mid-RUN -> all outputs 0 next cycle and LOCK_LOSS_CNT=0; with ENC_MON_STATS_EN undefined, scenario REQ-029 gives PERIOD=0 and an identical strobe.
